uart_rx_oversample: RTL

- UART receiver that sits directly downstream of the baud rate generator and consumes its rx_enb tick (16x the bit rate).
- Synchronises the serial line, detects and validates the start bit, and samples each data bit at mid-bit.
- Frames 8N1 bytes, LSB first, and presents each completed byte with a ready flag that the host clears.
- Reports framing and overrun errors.

---
 rtl/uart_rx_oversample_if.sv | 42 ++++
 rtl/uart_rx_oversample.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample_if.sv
// Receiver-side bundle for uart_rx_oversample: tick, serial line, clear strobe and byte status.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversample_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx_enb;
    logic                 rx;
    logic                 rdy_clr;
    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output rx_enb,
        output rx,
        output rdy_clr,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  data,
        input  rdy,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rx_enb,
        input  rx,
        input  rdy_clr,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output data,
        output rdy,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1 by default), sampling each bit at mid-bit from rx_enb ticks.
// Define UART_RX_PARITY_EN to add an even-parity bit and the sticky parity_err flag.
module uart_rx_oversample #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_oversample_if.slave  bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TickMid  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LastBit  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   rdy_q, rdy_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rxs;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err_q, parity_err_d;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.rx};
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rdy_d       = rdy_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        // Clear first so that a coinciding frame event below overrides it.
        if (bus.rdy_clr) begin
            rdy_d       = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end
        if (bus.rx_enb) begin
            unique case (state_q)
                StIdle: begin
                    tick_d = '0;
                    if (!rxs) state_d = StStart;
                end
                StStart: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TickMid) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxs ? StIdle : StData;
                    end
                end
                StData: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TickLast) begin
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 4'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_q == LastBit) state_d = StParity;
`else
                        if (bit_q == LastBit) state_d = StStop;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TickLast) begin
                        if ((^shift_q) != rxs) parity_err_d = 1'b1;
                        state_d = StStop;
                    end
                end
`endif
                StStop: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TickLast) begin
                        if (rxs) begin
                            data_d  = shift_q;
                            rdy_d   = 1'b1;
                            if (rdy_q && !bus.rdy_clr) overrun_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StWaitHigh;
                        end
                    end
                end
                StWaitHigh: begin
                    tick_d = '0;
                    if (rxs) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif
endmodule
